regfile_bank: RTL and testbench



---
 rtl/regfile_pkg.sv | 10 +
 rtl/bit_mux32.sv | 8 +
 rtl/reg_word.sv | 21 ++
 rtl/regfile_bank.sv | 69 ++++++
 tb/tb_regfile_bank.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit architectural register file.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/bit_mux32.sv
// Per-bit 32:1 select: picks one register's copy of a single data bit.
module bit_mux32 (
    input  logic [31:0] bits_i,
    input  logic [4:0]  sel_i,
    output logic        bit_o
);
    assign bit_o = bits_i[sel_i];
endmodule

// File: rtl/reg_word.sv
// One architectural register: enabled load, cleared immediately by async reset.
module reg_word #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] word_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            word_q <= '0;
        else if (en_i)
            word_q <= d_i;
    end

    assign q_o = word_q;
endmodule

// File: rtl/regfile_bank.sv
// 32 x 64 register file, one write port, two combinational read ports, X31 = 0.
// Define REGFILE_BYPASS_EN to forward WriteData to a read port addressing the write target.
module regfile_bank
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      RegWrite,
    input  reg_addr_t WriteRegister,
    input  reg_data_t WriteData,
    input  reg_addr_t ReadRegister1,
    input  reg_addr_t ReadRegister2,
    output reg_data_t ReadData1,
    output reg_data_t ReadData2
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-2:0]             wr_en;
    logic [DATA_W-1:0][NUM_REGS-1:0] bit_cols;
    reg_data_t                       mux_rd1, mux_rd2;

    assign regs_q[ZERO_REG] = '0;

    // Decoder output for address 31 is never built, so X31 writes vanish.
    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        assign wr_en[i] = RegWrite & (WriteRegister == reg_addr_t'(i));

        reg_word #(.W(DATA_W)) u_word (
            .clk   (clk),
            .reset (reset),
            .en_i  (wr_en[i]),
            .d_i   (WriteData),
            .q_o   (regs_q[i])
        );
    end

    // Transpose so each bit position sees {reg31[b]..reg0[b]} as one vector.
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
            assign bit_cols[b][r] = regs_q[r][b];
        end

        bit_mux32 u_mux1 (
            .bits_i (bit_cols[b]),
            .sel_i  (ReadRegister1),
            .bit_o  (mux_rd1[b])
        );

        bit_mux32 u_mux2 (
            .bits_i (bit_cols[b]),
            .sel_i  (ReadRegister2),
            .bit_o  (mux_rd2[b])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live, fwd1, fwd2;

    // Reset must win over forwarding so reads stay 0 while it is held.
    assign wr_live = RegWrite & ~reset & (WriteRegister != reg_addr_t'(ZERO_REG));
    assign fwd1    = wr_live & (WriteRegister == ReadRegister1);
    assign fwd2    = wr_live & (WriteRegister == ReadRegister2);

    assign ReadData1 = fwd1 ? WriteData : mux_rd1;
    assign ReadData2 = fwd2 ? WriteData : mux_rd2;
`else
    assign ReadData1 = mux_rd1;
    assign ReadData2 = mux_rd2;
`endif
endmodule

// File: tb/tb_regfile_bank.sv
// Directed self-checking bench for regfile_bank (both with and without REGFILE_BYPASS_EN).
module tb_regfile_bank;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      RegWrite;
    reg_addr_t WriteRegister;
    reg_data_t WriteData;
    reg_addr_t ReadRegister1;
    reg_addr_t ReadRegister2;
    reg_data_t ReadData1;
    reg_data_t ReadData2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam reg_data_t STEP = 64'h0101010101010101;

    regfile_bank dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input reg_data_t got, input reg_data_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input reg_addr_t a, input reg_data_t d);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = a;
        WriteData     = d;
        @(posedge clk);
        #1;
        RegWrite      = 1'b0;
    endtask

    task automatic rd(input reg_addr_t a1, input reg_addr_t a2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        @(posedge clk); #1;
        // Forwarding must not leak through while reset is held.
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 64'hCAFE;
        rd(5'd4, 5'd0);
        chk("reset_rd1", ReadData1, 64'h0);
        chk("reset_rd2", ReadData2, 64'h0);
        RegWrite = 1'b0;
        @(negedge clk); reset = 1'b0;

        // Async reset clears a live register without a clock edge.
        wr(5'd5, 64'hDEADBEEF_00000001);
        rd(5'd5, 5'd5);
        chk("x5_written", ReadData1, 64'hDEADBEEF_00000001);
        #1 reset = 1'b1;
        #1 chk("async_clear", ReadData1, 64'h0);
        @(negedge clk); reset = 1'b0;

        // Write in flight when reset is asserted is lost.
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h9999; reset = 1'b1;
        @(posedge clk); #1;
        RegWrite = 1'b0;
        @(negedge clk); reset = 1'b0;
        rd(5'd9, 5'd9);
        chk("write_lost", ReadData1, 64'h0);

        for (int i = 0; i < 31; i++) wr(reg_addr_t'(i), 64'(i) * STEP);
        for (int i = 0; i < 31; i++) begin
            rd(reg_addr_t'(i), reg_addr_t'(30 - i));
            chk($sformatf("all_rd1_x%0d", i), ReadData1, 64'(i) * STEP);
            chk($sformatf("all_rd2_x%0d", 30 - i), ReadData2, 64'(30 - i) * STEP);
        end
        rd(5'd31, 5'd31);
        chk("x31_rd1", ReadData1, 64'h0);

        wr(5'd31, 64'hFFFFFFFF_FFFFFFFF);
        rd(5'd31, 5'd31);
        chk("zero_rd1", ReadData1, 64'h0);
        chk("zero_rd2", ReadData2, 64'h0);
        for (int i = 0; i < 31; i++) begin
            rd(reg_addr_t'(i), 5'd31);
            chk($sformatf("zero_keep_x%0d", i), ReadData1, 64'(i) * STEP);
        end

        // X31 write with live RegWrite must still read 0, bypass or not.
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'h1;
        rd(5'd31, 5'd31);
        chk("zero_live", ReadData2, 64'h0);
        RegWrite = 1'b0;

        @(negedge clk);
        RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'h1234;
        repeat (5) @(posedge clk);
        #1 rd(5'd3, 5'd3);
        chk("wr_disable", ReadData1, 64'h0303030303030303);

        wr(5'd7, 64'hAA);
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h55;
        rd(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        chk("hazard_pre", ReadData1, 64'h55);
`else
        chk("hazard_pre", ReadData1, 64'hAA);
`endif
        @(posedge clk); #1;
        RegWrite = 1'b0;
        chk("hazard_post", ReadData1, 64'h55);

        wr(5'd12, 64'h0F0F);
        rd(5'd12, 5'd12);
        chk("dual_same1", ReadData1, 64'h0F0F);
        chk("dual_same2", ReadData2, 64'h0F0F);
        rd(5'd12, 5'd13);
        chk("dual_diff1", ReadData1, 64'h0F0F);
        chk("dual_diff2", ReadData2, 64'd13 * STEP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
